// File: rtl/period_meter.sv
`default_nettype none
// ============================================================================
//  Module      : period_meter
//  Description : Measures the period and high time of a slow asynchronous
//                square wave in clk_in cycles. Reports a fresh measurement
//                with a one-cycle valid pulse on every rising edge after the
//                first, and raises a sticky timeout flag when no rising edge
//                arrives within TIMEOUT cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module period_meter #(
    parameter int unsigned      WIDTH   = 28,
    parameter logic [WIDTH-1:0] TIMEOUT = 28'd200000000
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             valid,
    output logic             timeout,
    output logic             active
);

    // Last count value before the input is declared lost.
    localparam logic [WIDTH-1:0] TIMEOUT_M1 = TIMEOUT - 1'b1;
    localparam logic [WIDTH-1:0] CNT_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t           state_q,     state_d;

    // Synchroniser chain: s2 is the synchronised level, s3 its one-cycle-old
    // copy used only for edge detection.
    logic             s1_q,        s1_d;
    logic             s2_q,        s2_d;
    logic             s3_q,        s3_d;

    // cnt: cycles since last rise; hcnt: high cycles since last rise;
    // hlat: high count frozen at the falling edge of the current period.
    logic [WIDTH-1:0] cnt_q,       cnt_d;
    logic [WIDTH-1:0] hcnt_q,      hcnt_d;
    logic [WIDTH-1:0] hlat_q,      hlat_d;

    // Registered outputs.
    logic [WIDTH-1:0] period_q,    period_d;
    logic [WIDTH-1:0] high_time_q, high_time_d;
    logic             valid_q,     valid_d;
    logic             timeout_q,   timeout_d;
    logic             active_q,    active_d;

    logic             w_rise;
    logic             w_fall;

    // Edge detection on the synchronised level.
    always_comb begin
        w_rise = s2_q & ~s3_q;
        w_fall = ~s2_q & s3_q;
    end

    // Next-state logic for the synchroniser, counters, FSM and outputs.
    always_comb begin
        s1_d        = sig_in;
        s2_d        = s1_q;
        s3_d        = s2_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        hcnt_d      = hcnt_q;
        hlat_d      = hlat_q;
        period_d    = period_q;
        high_time_d = high_time_q;
        valid_d     = 1'b0;
        timeout_d   = timeout_q;

        case (state_q)
            ST_IDLE: begin
                // First rise only arms the measurement; there is no
                // complete period to report yet. The rise cycle itself is
                // the first high cycle of the new period.
                if (w_rise) begin
                    cnt_d   = '0;
                    hcnt_d  = CNT_ONE;
                    hlat_d  = '0;
                    state_d = ST_MEASURE;
                end
            end

            ST_MEASURE: begin
                if (w_rise) begin
                    // A rise wins over a coincident timeout, so a period of
                    // exactly TIMEOUT cycles is still reported.
                    period_d    = cnt_q + 1'b1;
                    high_time_d = hlat_q;
                    valid_d     = 1'b1;
                    timeout_d   = 1'b0;
                    cnt_d       = '0;
                    hcnt_d      = CNT_ONE;
                end else if (cnt_q == TIMEOUT_M1) begin
                    // Input lost: keep the last measurement, flag it, and
                    // require a fresh arming rise.
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (s2_q) begin
                        hcnt_d = hcnt_q + 1'b1;
                    end
                    if (w_fall) begin
                        hlat_d = hcnt_q;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        active_d = (state_d == ST_MEASURE);
    end

    // All state flops with synchronous active-high reset.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            s3_q        <= 1'b0;
            cnt_q       <= '0;
            hcnt_q      <= '0;
            hlat_q      <= '0;
            period_q    <= '0;
            high_time_q <= '0;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            s3_q        <= s3_d;
            cnt_q       <= cnt_d;
            hcnt_q      <= hcnt_d;
            hlat_q      <= hlat_d;
            period_q    <= period_d;
            high_time_q <= high_time_d;
            valid_q     <= valid_d;
            timeout_q   <= timeout_d;
            active_q    <= active_d;
        end
    end

    // Output drive from registered copies.
    always_comb begin
        period    = period_q;
        high_time = high_time_q;
        valid     = valid_q;
        timeout   = timeout_q;
        active    = active_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_period_meter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_period_meter
//  Description : Self-checking bench for period_meter. Stimulus tasks push
//                the expected (period, high_time) of each reportable rise
//                into a queue; a monitor pops and compares on every valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_period_meter;

    localparam int unsigned W = 28;

    logic         clk_in = 1'b0;
    logic         rst    = 1'b1;
    logic         sig_in = 1'b0;

    logic [W-1:0] period_a, high_time_a, period_b, high_time_b;
    logic         valid_a, timeout_a, active_a;
    logic         valid_b, timeout_b, active_b;

    // Main instance with a short timeout for the loss-of-signal tests.
    period_meter #(.WIDTH(W), .TIMEOUT(28'd100)) dut_a (
        .clk_in    (clk_in),
        .rst       (rst),
        .sig_in    (sig_in),
        .period    (period_a),
        .high_time (high_time_a),
        .valid     (valid_a),
        .timeout   (timeout_a),
        .active    (active_a)
    );

    // Instance for the rise-at-timeout boundary.
    period_meter #(.WIDTH(W), .TIMEOUT(28'd16)) dut_b (
        .clk_in    (clk_in),
        .rst       (rst),
        .sig_in    (sig_in),
        .period    (period_b),
        .high_time (high_time_b),
        .valid     (valid_b),
        .timeout   (timeout_b),
        .active    (active_b)
    );

    always #5 clk_in = ~clk_in;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Scoreboard and bench-side waveform model.
    typedef struct packed {
        logic [31:0] per;
        logic [31:0] hi;
    } exp_t;
    exp_t        sb[$];
    bit          armed = 1'b0;
    int unsigned prev_p = 0;
    int unsigned prev_h = 0;
    bit          sel_b  = 1'b0;
    int unsigned n_valid = 0;
    int unsigned cyc = 0;
    int unsigned last_rise_cyc = 0;
    int unsigned last_valid_cyc = 0;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Record a driven rise: it reports the previous period if the meter is armed.
    task automatic note_rise(input int unsigned h, input int unsigned l);
        last_rise_cyc = cyc;
        if (armed) sb.push_back('{per: prev_p, hi: prev_h});
        armed  = 1'b1;
        prev_p = h + l;
        prev_h = h;
    endtask

    task automatic wave(input int unsigned h, input int unsigned l, input int unsigned n);
        for (int unsigned c = 0; c < n; c++) begin
            for (int unsigned i = 0; i < h + l; i++) begin
                @(posedge clk_in); #1;
                sig_in = (i < h);
                if (i == 0) note_rise(h, l);
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk_in); #1 rst = 1'b1;
        @(posedge clk_in); #1 rst = 1'b0;
        armed = 1'b0;
    endtask

    // Monitor: every valid must match the oldest expected measurement.
    always @(negedge clk_in) begin
        logic         v, t;
        logic [W-1:0] p, h;
        exp_t         e;
        v = sel_b ? valid_b     : valid_a;
        t = sel_b ? timeout_b   : timeout_a;
        p = sel_b ? period_b    : period_a;
        h = sel_b ? high_time_b : high_time_a;
        if (!rst && v) begin
            n_valid++;
            last_valid_cyc = cyc;
            if (sb.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("period", 32'(p), e.per);
                check("high_time", 32'(h), e.hi);
                check("timeout_at_valid", 32'(t), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state.
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        check("rst_period",    32'(period_a),    32'd0);
        check("rst_high_time", 32'(high_time_a), 32'd0);
        check("rst_valid",     32'(valid_a),     32'd0);
        check("rst_timeout",   32'(timeout_a),   32'd0);
        check("rst_active",    32'(active_a),    32'd0);
        #1 rst = 1'b0;

        // 50% duty 5/5, plus latency of the second rise (sampling edge + 2).
        wave(5, 5, 2);
        check("latency", last_valid_cyc - last_rise_cyc, 32'd3);
        wave(5, 5, 2);

        // Loss of signal: hold low after the last rise of the 10-cycle wave.
        repeat (93) @(posedge clk_in);
        @(negedge clk_in);
        check("to_before_flag",   32'(timeout_a), 32'd0);
        check("to_before_active", 32'(active_a),  32'd1);
        @(posedge clk_in);
        @(negedge clk_in);
        check("to_flag",      32'(timeout_a),   32'd1);
        check("to_active",    32'(active_a),    32'd0);
        check("to_period",    32'(period_a),    32'd10);
        check("to_high_time", 32'(high_time_a), 32'd5);
        armed = 1'b0;

        // Resume: first rise re-arms only; flag stays sticky until a valid.
        wave(5, 5, 1);
        check("resume_timeout_sticky", 32'(timeout_a), 32'd1);
        check("resume_active",         32'(active_a),  32'd1);
        wave(5, 5, 1);
        check("resume_timeout_clear",  32'(timeout_a), 32'd0);

        // Divider-style 3/4 waveform, five cycles -> four valids.
        do_reset();
        n_valid = 0;
        wave(3, 4, 5);
        repeat (5) @(posedge clk_in);
        check("div_valid_count", n_valid, 32'd4);

        // Minimum period 1/1.
        do_reset();
        n_valid = 0;
        wave(1, 1, 6);
        repeat (5) @(posedge clk_in);
        check("min_valid_count", n_valid, 32'd5);

        // Reset in the low phase of a 20-cycle wave.
        do_reset();
        wave(10, 10, 3);
        for (int unsigned i = 0; i < 20; i++) begin
            @(posedge clk_in); #1;
            sig_in = (i < 10);
            rst    = (i == 13);
            if (i == 0) note_rise(10, 10);
            if (i == 14) begin
                armed = 1'b0;
                @(negedge clk_in);
                check("mid_rst_period",    32'(period_a),    32'd0);
                check("mid_rst_high_time", 32'(high_time_a), 32'd0);
                check("mid_rst_valid",     32'(valid_a),     32'd0);
                check("mid_rst_timeout",   32'(timeout_a),   32'd0);
                check("mid_rst_active",    32'(active_a),    32'd0);
            end
        end
        n_valid = 0;
        wave(10, 10, 2);
        repeat (5) @(posedge clk_in);
        check("post_rst_valid_count", n_valid, 32'd1);

        // Rise exactly at cnt == TIMEOUT-1 on the TIMEOUT=16 instance.
        do_reset();
        sel_b   = 1'b1;
        n_valid = 0;
        wave(8, 8, 3);
        check("bnd_active",      32'(active_b),  32'd1);
        check("bnd_timeout",     32'(timeout_b), 32'd0);
        check("bnd_valid_count", n_valid,        32'd2);

        repeat (5) @(posedge clk_in);
        check("sb_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
